ledseq_ctrl: RTL and testbench

Playlist sequencer for the 8-LED running-light bar. It steps through a 4-entry playlist in which each entry selects a light pattern, a speed, a direction and a repeat count. It generates its own step ticks from the system clock and accepts debounced button pulses for pause/resume and skip-to-next. It sits between the debounce instances and the LED/7-segment outputs; the top level inverts `led` for the active-low LED pins and feeds `step_idx`/`cur_speed`/`cur_dir` to the hexdigit instances.

---
 rtl/ledseq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ledseq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ledseq_ctrl.sv
// rtl/ledseq_ctrl.sv - 4-entry LED playlist sequencer with tick divider and run/pause/skip control
// Optional LEDSEQ_PROG_EN makes the playlist writable; otherwise it is a constant table.
module ledseq_ctrl #(
    parameter int BASE_DIV = 1250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_pause,
    input  logic       prog_we,
    input  logic [1:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] led,
    output logic [1:0] step_idx,
    output logic [1:0] cur_speed,
    output logic       cur_dir,
    output logic       paused,
    output logic       step_pulse
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_PAUSE} state_t;

    localparam logic [25:0] BASE = 26'(BASE_DIV);

    state_t      state, state_n;
    logic [7:0]  entry;
    logic [1:0]  cur_pat, cur_pat_n;
    logic [2:0]  rep_cnt, rep_cnt_n;
    logic [25:0] tick_cnt, tick_cnt_n;
    logic        bounce_up, bounce_up_n;
    logic [7:0]  led_n;
    logic [1:0]  step_idx_n, cur_speed_n;
    logic        cur_dir_n;
    logic [25:0] period;
    logic        wrap;
    logic [7:0]  adv_led;
    logic        adv_up;
    logic        cycle_done;

    function automatic logic [7:0] default_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h24;
            2'd1:    return 8'h01;
            2'd2:    return 8'h1A;
            default: return 8'h63;
        endcase
    endfunction

    function automatic logic [7:0] init_led(input logic [1:0] pat, input logic dir);
        if (pat == 2'd3)
            return dir ? 8'hAA : 8'h55;
        return dir ? 8'h80 : 8'h01;
    endfunction

`ifdef LEDSEQ_PROG_EN
    logic [7:0] playlist [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                playlist[i] <= default_entry(2'(i));
        end else if (prog_we) begin
            playlist[prog_addr] <= prog_data;
        end
    end

    assign entry = playlist[step_idx];
`else
    logic prog_unused;
    assign prog_unused = ^{prog_we, prog_addr, prog_data};
    assign entry = default_entry(step_idx);
`endif

    assign period     = BASE << cur_speed;
    assign wrap       = (tick_cnt == period - 26'd1);
    assign paused     = (state == S_PAUSE);
    assign step_pulse = (state == S_LOAD) && !rst;

    // Next LED value on a tick; bounce_up tracks the travel direction of BOUNCE.
    always_comb begin
        adv_led = led;
        adv_up  = bounce_up;
        case (cur_pat)
            2'd0: adv_led = cur_dir ? {led[0], led[7:1]} : {led[6:0], led[7]};
            2'd1: begin
                adv_led = bounce_up ? (led << 1) : (led >> 1);
                adv_up  = bounce_up ? !adv_led[7] : adv_led[0];
            end
            2'd2: begin
                if (led == 8'hFF)
                    adv_led = 8'h00;
                else
                    adv_led = cur_dir ? {1'b1, led[7:1]} : {led[6:0], 1'b1};
            end
            default: adv_led = ~led;
        endcase
    end

    assign cycle_done = (adv_led == init_led(cur_pat, cur_dir));

    always_comb begin
        state_n     = state;
        led_n       = led;
        step_idx_n  = step_idx;
        cur_pat_n   = cur_pat;
        cur_speed_n = cur_speed;
        cur_dir_n   = cur_dir;
        rep_cnt_n   = rep_cnt;
        tick_cnt_n  = tick_cnt;
        bounce_up_n = bounce_up;
        case (state)
            S_LOAD: begin
                cur_pat_n   = entry[1:0];
                cur_speed_n = entry[3:2];
                cur_dir_n   = entry[4];
                rep_cnt_n   = entry[7:5];
                tick_cnt_n  = 26'd0;
                led_n       = init_led(entry[1:0], entry[4]);
                bounce_up_n = !entry[4];
                state_n     = S_RUN;
            end
            S_RUN: begin
                if (btn_next) begin
                    step_idx_n = step_idx + 2'd1;
                    state_n    = S_LOAD;
                end else if (btn_pause) begin
                    state_n = S_PAUSE;
                end else if (wrap) begin
                    tick_cnt_n  = 26'd0;
                    led_n       = adv_led;
                    bounce_up_n = adv_up;
                    if (cycle_done) begin
                        if (rep_cnt == 3'd0) begin
                            step_idx_n = step_idx + 2'd1;
                            state_n    = S_LOAD;
                        end else begin
                            rep_cnt_n = rep_cnt - 3'd1;
                        end
                    end
                end else begin
                    tick_cnt_n = tick_cnt + 26'd1;
                end
            end
            S_PAUSE: begin
                if (btn_next) begin
                    step_idx_n = step_idx + 2'd1;
                    state_n    = S_LOAD;
                end else if (btn_pause) begin
                    state_n = S_RUN;
                end
            end
            default: state_n = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_LOAD;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= 8'h00;
            step_idx  <= 2'd0;
            cur_pat   <= 2'd0;
            cur_speed <= 2'd0;
            cur_dir   <= 1'b0;
            rep_cnt   <= 3'd0;
            tick_cnt  <= 26'd0;
            bounce_up <= 1'b1;
        end else begin
            led       <= led_n;
            step_idx  <= step_idx_n;
            cur_pat   <= cur_pat_n;
            cur_speed <= cur_speed_n;
            cur_dir   <= cur_dir_n;
            rep_cnt   <= rep_cnt_n;
            tick_cnt  <= tick_cnt_n;
            bounce_up <= bounce_up_n;
        end
    end

endmodule

// File: tb/tb_ledseq_ctrl.sv
// tb/tb_ledseq_ctrl.sv - self-checking bench for ledseq_ctrl (BASE_DIV=4, optional LEDSEQ_PROG_EN)
module tb_ledseq_ctrl;

    logic       clk = 1'b0;
    logic       rst, btn_next, btn_pause, prog_we;
    logic [1:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] led;
    logic [1:0] step_idx, cur_speed;
    logic       cur_dir, paused, step_pulse;

    always #5 clk = ~clk;

    ledseq_ctrl #(.BASE_DIV(4)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_pause(btn_pause),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .led(led), .step_idx(step_idx), .cur_speed(cur_speed), .cur_dir(cur_dir),
        .paused(paused), .step_pulse(step_pulse)
    );

    int errors = 0;
    int checks = 0;
    int rel = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, rel);
        end
    endtask

    // Model: the pattern is a position in a per-pattern sequence, LEDs derived arithmetically.
    localparam logic [7:0] DEF_PL [4] = '{8'h24, 8'h01, 8'h1A, 8'h63};

    function automatic int pat_len(input int p);
        case (p)
            0:       return 8;
            1:       return 14;
            2:       return 9;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] pat_val(input int p, input int d, input int pos);
        logic [7:0] v, r;
        int k;
        case (p)
            0: v = 8'h01 << pos;
            1: begin
                k = (pos <= 7) ? pos : 14 - pos;
                v = 8'h01 << k;
            end
            2: v = (pos < 8) ? 8'((1 << (pos + 1)) - 1) : 8'h00;
            default: v = (pos == 0) ? 8'h55 : 8'hAA;
        endcase
        for (int b = 0; b < 8; b++) r[b] = v[7 - b];
        return (d != 0) ? r : v;
    endfunction

    logic [7:0] m_pl [4];
    logic [7:0] m_ent;
    logic [7:0] m_led;
    int m_mode, m_idx, m_pat, m_spd, m_dir, m_rep, m_pos, m_cnt;
    bit m_init = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && m_init) begin
                chk("led", led, m_led);
                chk("step_idx", step_idx, m_idx);
                chk("cur_speed", cur_speed, m_spd);
                chk("cur_dir", cur_dir, m_dir);
                chk("paused", paused, (m_mode == 2));
                chk("step_pulse", step_pulse, (m_mode == 0) && !rst);
            end
            if (rst) begin
                m_init = 1'b1;
                m_mode = 0; m_idx = 0; m_led = 8'h00; m_spd = 0; m_dir = 0;
                m_pat = 0; m_rep = 0; m_pos = 0; m_cnt = 0;
                m_pl = DEF_PL;
            end else if (m_init) begin
                case (m_mode)
                    0: begin
                        m_ent = m_pl[m_idx];
                        m_pat = int'(m_ent[1:0]);
                        m_spd = int'(m_ent[3:2]);
                        m_dir = int'(m_ent[4]);
                        m_rep = int'(m_ent[7:5]);
                        m_pos = 0;
                        m_cnt = 0;
                        m_led = pat_val(m_pat, m_dir, 0);
                        m_mode = 1;
                    end
                    1: begin
                        if (btn_next) begin
                            m_idx = (m_idx + 1) % 4;
                            m_mode = 0;
                        end else if (btn_pause) begin
                            m_mode = 2;
                        end else if (m_cnt == (4 << m_spd) - 1) begin
                            m_cnt = 0;
                            m_pos = (m_pos + 1) % pat_len(m_pat);
                            m_led = pat_val(m_pat, m_dir, m_pos);
                            if (m_pos == 0) begin
                                if (m_rep == 0) begin
                                    m_idx = (m_idx + 1) % 4;
                                    m_mode = 0;
                                end else begin
                                    m_rep--;
                                end
                            end
                        end else begin
                            m_cnt++;
                        end
                    end
                    default: begin
                        if (btn_next) begin
                            m_idx = (m_idx + 1) % 4;
                            m_mode = 0;
                        end else if (btn_pause) begin
                            m_mode = 1;
                        end
                    end
                endcase
`ifdef LEDSEQ_PROG_EN
                if (prog_we) m_pl[prog_addr] = prog_data;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        rel++;
    endtask

    task automatic goto(input int n);
        while (rel < n) step();
    endtask

    task automatic press(input bit nxt, input bit pse);
        btn_next = nxt;
        btn_pause = pse;
        step();
        btn_next = 1'b0;
        btn_pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_next = 1'b0; btn_pause = 1'b0;
        prog_we = 1'b0; prog_addr = 2'd0; prog_data = 8'h00;
        @(posedge clk); #2;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst led", led, 8'h00);
        chk("rst step_pulse", step_pulse, 1'b0);
        chk("rst paused", paused, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        rel = 0;
        #1;
        chk("first step_pulse", step_pulse, 1'b1);
        chk("first step_idx", step_idx, 2'd0);

        goto(1);   chk("e0 init led", led, 8'h01); chk("e0 pulse low", step_pulse, 1'b0);
        goto(8);   chk("e0 before tick", led, 8'h01);
        goto(9);   chk("e0 tick1", led, 8'h02);
        goto(57);  chk("e0 tick7", led, 8'h80);
        goto(128); chk("e0 last idx", step_idx, 2'd0);
        goto(129); chk("e1 load idx", step_idx, 2'd1); chk("e1 load pulse", step_pulse, 1'b1);
        goto(130); chk("e1 init led", led, 8'h01); chk("e1 speed", cur_speed, 2'd0);
        goto(158); chk("e1 top", led, 8'h80);
        goto(185); chk("e1 near end", led, 8'h02); chk("e1 idx", step_idx, 2'd1);
        goto(186); chk("e2 idx", step_idx, 2'd2);
        goto(187); chk("e2 init led", led, 8'h80); chk("e2 speed", cur_speed, 2'd2);
        chk("e2 dir", cur_dir, 1'b1);

        goto(190); press(1'b1, 1'b0);
        chk("skip idx", step_idx, 2'd3);
        goto(192); chk("e3 init led", led, 8'h55);

        goto(200); press(1'b1, 1'b1);
        chk("next+pause idx", step_idx, 2'd0); chk("next+pause paused", paused, 1'b0);
        goto(202); chk("next+pause led", led, 8'h01);

        goto(207); press(1'b0, 1'b1);
        chk("pause on", paused, 1'b1);
        goto(308); chk("pause hold led", led, 8'h01); chk("pause hold", paused, 1'b1);
        press(1'b0, 1'b1);
        chk("pause off", paused, 1'b0);
        goto(311); chk("resume before tick", led, 8'h01);
        goto(312); chk("resume tick", led, 8'h02);

        goto(431); chk("pre coincide led", led, 8'h80); chk("pre coincide idx", step_idx, 2'd0);
        press(1'b1, 1'b0);
        chk("coincide idx", step_idx, 2'd1);
        goto(433); chk("coincide led", led, 8'h01);

        goto(440); press(1'b1, 1'b0);
        goto(445); press(1'b1, 1'b0);
        goto(450); press(1'b1, 1'b0);
        goto(455);
        prog_we = 1'b1; prog_addr = 2'd0; prog_data = 8'h1C;
        step();
        prog_we = 1'b0;
        chk("write active led", led, 8'h01); chk("write active speed", cur_speed, 2'd1);
        goto(460); chk("write active tick", led, 8'h02);
        goto(462); press(1'b1, 1'b0);
        goto(466); press(1'b1, 1'b0);
        goto(470); press(1'b1, 1'b0);
        goto(474); press(1'b1, 1'b0);
        goto(476);
`ifdef LEDSEQ_PROG_EN
        chk("prog led", led, 8'h80); chk("prog speed", cur_speed, 2'd3); chk("prog dir", cur_dir, 1'b1);
        goto(507); chk("prog before tick", led, 8'h80);
        goto(508); chk("prog tick", led, 8'h40);
`else
        chk("noprog led", led, 8'h01); chk("noprog speed", cur_speed, 2'd1); chk("noprog dir", cur_dir, 1'b0);
        goto(483); chk("noprog before tick", led, 8'h01);
        goto(484); chk("noprog tick", led, 8'h02);
`endif

        goto(512);
        rst = 1'b1;
        step();
        chk("mid rst led", led, 8'h00); chk("mid rst idx", step_idx, 2'd0);
        chk("mid rst speed", cur_speed, 2'd0); chk("mid rst pulse", step_pulse, 1'b0);
        rst = 1'b0;
        btn_pause = 1'b1;
        #1;
        chk("post rst pulse", step_pulse, 1'b1);
        step();
        btn_pause = 1'b0;
        chk("load ignores pause", paused, 1'b0);
        chk("reload led", led, 8'h01); chk("reload speed", cur_speed, 2'd1);
        goto(524); chk("reload tick", led, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
